// File: rtl/tx_8b10b_if.sv
// Transmit-encoder bus: byte/select from the PCS transmit state machine, code group and status back.
interface tx_8b10b_if;
  logic [7:0] txd;
  logic [3:0] tx_enc_ctrl_sel;
  logic [9:0] tx_10bdata;
  logic       tx_rd;
  logic       enc_ready;
  logic       enc_err;

  modport master (
    output txd, tx_enc_ctrl_sel,
    input  tx_10bdata, tx_rd, enc_ready, enc_err
  );

  modport slave (
    input  txd, tx_enc_ctrl_sel,
    output tx_10bdata, tx_rd, enc_ready, enc_err
  );
endinterface

// File: rtl/tx_8b10b_encoder.sv
// 1000BASE-X 8b/10b transmit encoder with running-disparity tracking and two-slot /I/ generation.
module tx_8b10b_encoder (
  input  logic        clk,
  input  logic        rst_n,
  tx_8b10b_if.slave   bus
);

  typedef enum logic {NORMAL, IDLE2} state_t;
  typedef enum logic {I1, I2}        i_kind_t;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;

  state_t      state;
  i_kind_t     i_kind;
  logic        rd;
  logic [9:0]  code_q;
  logic        err_q;

  logic [7:0]  enc_byte;
  logic        enc_k;
  logic        err_n;
  logic [10:0] enc;

  // RD- column of the 5b/6b table, written abcdei with a in the MSB.
  function automatic logic [5:0] six_minus(input logic [4:0] x);
    case (x)
      5'd0:  return 6'b100111;  5'd1:  return 6'b011101;
      5'd2:  return 6'b101101;  5'd3:  return 6'b110001;
      5'd4:  return 6'b110101;  5'd5:  return 6'b101001;
      5'd6:  return 6'b011001;  5'd7:  return 6'b111000;
      5'd8:  return 6'b111001;  5'd9:  return 6'b100101;
      5'd10: return 6'b010101;  5'd11: return 6'b110100;
      5'd12: return 6'b001101;  5'd13: return 6'b101100;
      5'd14: return 6'b011100;  5'd15: return 6'b010111;
      5'd16: return 6'b011011;  5'd17: return 6'b100011;
      5'd18: return 6'b010011;  5'd19: return 6'b110010;
      5'd20: return 6'b001011;  5'd21: return 6'b101010;
      5'd22: return 6'b011010;  5'd23: return 6'b111010;
      5'd24: return 6'b110011;  5'd25: return 6'b100110;
      5'd26: return 6'b010110;  5'd27: return 6'b110110;
      5'd28: return 6'b001110;  5'd29: return 6'b101110;
      5'd30: return 6'b011110;  default: return 6'b101011;
    endcase
  endfunction

  // RD- column of the 3b/4b table, written fghj with f in the MSB.
  function automatic logic [3:0] four_minus(input logic [2:0] y);
    case (y)
      3'd0: return 4'b1011;  3'd1: return 4'b1001;
      3'd2: return 4'b0101;  3'd3: return 4'b1100;
      3'd4: return 4'b1101;  3'd5: return 4'b1010;
      3'd6: return 4'b0110;  default: return 4'b1110;
    endcase
  endfunction

  function automatic logic [5:0] rev6(input logic [5:0] v);
    for (int i = 0; i < 6; i++) rev6[i] = v[5-i];
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] v);
    for (int i = 0; i < 4; i++) rev4[i] = v[3-i];
  endfunction

  // Returns {rd_after, j,h,g,f,i,e,d,c,b,a}.
  function automatic logic [10:0] encode(input logic [7:0] b, input logic k, input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] s;
    logic [3:0] f;
    logic       rd_mid;
    logic       rd_out;
    logic       a7;
    x = b[4:0];
    y = b[7:5];
    s = (k && x == 5'd28) ? 6'b001111 : six_minus(x);
    rd_mid = ($countones(s) == 3) ? rd_in : ~rd_in;
    if (rd_in && ($countones(s) != 3 || s == 6'b111000)) s = ~s;
    a7 = (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
         ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14));
    // Supported K codes are K28.5 and K.x.7; K.x.7 always takes the alternate form.
    if (k)                   f = (y == 3'd7) ? 4'b0111 : 4'b0101;
    else if (y == 3'd7 && a7) f = 4'b0111;
    else                     f = four_minus(y);
    rd_out = ($countones(f) == 2) ? rd_mid : ~rd_mid;
    if (rd_mid && ($countones(f) != 2 || f == 4'b1100 || k)) f = ~f;
    return {rd_out, rev4(f), rev6(s)};
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    enc_byte = bus.txd;
    enc_k    = 1'b0;
    err_n    = 1'b0;
    if (state == IDLE2) begin
      enc_byte = (i_kind == I1) ? D5_6 : D16_2;
    end else begin
      case (bus.tx_enc_ctrl_sel)
        4'd0:    enc_k = 1'b0;
        4'd1:    begin enc_byte = K28_5; enc_k = 1'b1; end
        4'd2:    begin enc_byte = K27_7; enc_k = 1'b1; end
        4'd3:    begin enc_byte = K29_7; enc_k = 1'b1; end
        4'd4:    begin enc_byte = K23_7; enc_k = 1'b1; end
        4'd5:    begin enc_byte = K30_7; enc_k = 1'b1; end
        4'd6:    begin enc_byte = K28_5; enc_k = 1'b1; end
        default: begin enc_byte = K30_7; enc_k = 1'b1; err_n = 1'b1; end
      endcase
    end
    enc = encode(enc_byte, enc_k, rd);
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous and wins over everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= NORMAL;
      i_kind <= I2;
      rd     <= 1'b0;
      code_q <= 10'h000;
      err_q  <= 1'b0;
    end else begin
      code_q <= enc[9:0];
      rd     <= enc[10];
      err_q  <= err_n;
      if (state == NORMAL && bus.tx_enc_ctrl_sel == 4'd6) begin
        state  <= IDLE2;
        i_kind <= rd ? I1 : I2;
      end else begin
        state  <= NORMAL;
      end
    end
  end

  assign bus.tx_10bdata = code_q;
  assign bus.tx_rd      = rd;
  assign bus.enc_err    = err_q;
  assign bus.enc_ready  = (state == NORMAL);

endmodule

// File: doc/tx_8b10b_encoder.md
# tx_8b10b_encoder

Transmit-side 1000BASE-X 8b/10b encoder with running-disparity (RD) tracking and /I/ ordered-set generation. Converts a byte plus a control-select code from the PCS transmit state machine into one 10-bit code group per cycle. Feeds the registered 10-bit decode path (`tx_10bdata`). The pair must round-trip: encoder output decoded back yields the original `txd`/`tx_enc_ctrl_sel`.

## Interface
- No parameters.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `txd` input 8: data byte, HGFEDCBA; bit 0 = A.
- `tx_enc_ctrl_sel` input 4: code-group select (see Operation).
- `tx_10bdata` output 10: registered code group, `{j,h,g,f,i,e,d,c,b,a}`; bit 0 = a, first on the wire.
- `tx_rd` output 1: RD after the current `tx_10bdata` (0 = negative, 1 = positive).
- `enc_ready` output 1: inputs sampled this cycle when high; low only during the second slot of /I/.
- `enc_err` output 1: one-cycle pulse, aligned with `tx_10bdata`, when an unsupported select was replaced by /V/.

## Operation
- `tx_enc_ctrl_sel` decode, applied when `enc_ready`=1:
  - 0: data Dx.y from `txd`.
  - 1: K28.5.
  - 2: /S/ K27.7.
  - 3: /T/ K29.7.
  - 4: /R/ K23.7.
  - 5: /V/ K30.7.
  - 6: /I/ ordered set, two code groups.
  - 7–15: /V/ K30.7, plus `enc_err` pulse.
  - In control cases `txd` is ignored.
- Encoding per IEEE 802.3 Clause 36 tables.
  - 5b/6b sub-block selected by RD at block entry.
  - 3b/4b sub-block selected by RD after the 6b sub-block.
  - RD flips after a sub-block only when it is unbalanced (disparity ±2). 000111/111000 and 0011/1100 count as neutral.
  - D.x.7 alternate (A7) used when required:
    - RD− with x ∈ {17,18,20}.
    - RD+ with x ∈ {11,13,14}.
- State machine, states NORMAL and IDLE2:
  - NORMAL + sel=6: emit K28.5 with current RD. Latch `i_kind` = I1 if the pre-K28.5 RD was positive, else I2. Go to IDLE2; `enc_ready` deasserts for the next cycle.
  - IDLE2: emit D5.6 for I1 or D16.2 for I2, using RD after the K28.5. Inputs ignored. Return to NORMAL.
  - An /I/ set always leaves RD negative.
  - Back-to-back sel=6 gives a continuous I1/I2 stream. After the first set, every set is I2.
- Reset (`rst_n`=0 at a rising edge), all take effect next cycle:
  - `tx_10bdata`=10'h000.
  - RD negative, `tx_rd`=0.
  - state NORMAL, `enc_ready`=1, `enc_err`=0.
- Reset mid-ordered-set (in IDLE2) abandons the second code group. First post-reset code uses RD−.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on `tx_10bdata`/`tx_rd`/`enc_err` after edge N.
- Throughput one code group per cycle. No stall except the fixed IDLE2 slot.
- `enc_ready` is combinational from state. It is low exactly in the cycle whose edge produces the second /I/ code group.
- RD register updates on the same edge as `tx_10bdata`. `tx_rd` always equals the RD used for the next encode.
- Reset has priority over every other event on the same edge.

## Test plan
- Reset then sel=1 → `tx_10bdata`=0x17C (K28.5 RD−), `tx_rd`=1. Second sel=1 → 0x283 (K28.5 RD+), `tx_rd`=0.
- From RD−, sel=0, txd=0x00 → 0x0B9 (D0.0), `tx_rd`=0. txd=0xB5 → 0x155 (D21.5) under both RD, RD unchanged.
- sel=6 held 4 cycles from RD−:
  - `tx_10bdata` = 0x17C, then D16.2 (RD+ column), then K28.5 RD−, then D16.2.
  - `enc_ready` pattern 1,0,1,0.
  - `tx_rd`=0 after each set.
- Force RD+ (one K28.5), then sel=6 → K28.5 RD+ (0x283) followed by D5.6. Ends RD−.
- sel=9 → K30.7 code for current RD, `enc_err`=1 for one cycle only. sel=5 → same code, `enc_err`=0.
- Exhaustive loop: all 256 data bytes plus codes 1–6, in random order and random RD, fed through encoder then decoder.
  - Recovered `txd`/`tx_enc_ctrl_sel` must match.
  - Every code group has ≤6 ones and run length ≤5.
  - Include `rst_n` pulsed during IDLE2 → next output follows RD− tables.
